// File: rtl/pool_stream_pkg.sv
// Shared types and default geometry for the streaming pooling block.
package pool_stream_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pool_stream_state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_IMG_W      = 28;
  localparam int DEF_IMG_H      = 28;
  localparam int DEF_POOL_K     = 2;

  // Bits gained by summing a K x K window; also the average divide shift.
  function automatic int pool_shift(input int k);
    return 2 * $clog2(k);
  endfunction

endpackage

// File: rtl/pool_combine.sv
// Combines one sign-extended pixel into a window accumulator entry.
module pool_combine
  import pool_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_DATA_WIDTH + 2
) (
  input  logic                  init,
  input  pool_mode_t            mode,
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic [DATA_WIDTH-1:0] pixel,
  output logic [ACC_WIDTH-1:0]  result
);

  logic [ACC_WIDTH-1:0] px_ext;

  assign px_ext = {{(ACC_WIDTH-DATA_WIDTH){pixel[DATA_WIDTH-1]}}, pixel};

  always_comb begin
    result = px_ext;
    if (!init) begin
      if (mode == POOL_AVG) begin
        result = acc + px_ext;
      end else if ($signed(px_ext) > $signed(acc)) begin
        result = px_ext;
      end else begin
        result = acc;
      end
    end
  end

endmodule

// File: rtl/pool_stream.sv
// Streaming K x K non-overlapping max/average pooling over a raster-order frame.
//
// state | meaning
// IDLE  | waiting for start; input and output idle
// RUN   | accepting pixels of the current frame
// DRAIN | last pixel taken; waiting for last result to be accepted
module pool_stream
  import pool_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int POOL_K     = DEF_POOL_K
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int LOG2K     = $clog2(POOL_K);
  localparam int SHIFT     = pool_shift(POOL_K);
  localparam int ACC_WIDTH = DATA_WIDTH + SHIFT;
  localparam int NCOL      = IMG_W / POOL_K;
  localparam int CW        = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW        = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int IW        = (NCOL > 1) ? $clog2(NCOL) : 1;

  if ((POOL_K != 2 && POOL_K != 4) || (IMG_W % POOL_K) != 0 || (IMG_H % POOL_K) != 0) begin : g_bad_cfg
    $fatal(1, "pool_stream: POOL_K must be 2 or 4 and divide IMG_W and IMG_H");
  end

  pool_stream_state_t    state_q, state_d;
  pool_mode_t            mode_q;
  logic [CW-1:0]         col_q;
  logic [RW-1:0]         row_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  frame_done_q;
  logic [ACC_WIDTH-1:0]  acc_buf [NCOL];

  logic                  px_fire, out_fire;
  logic                  win_first, win_last, last_px;
  logic [IW-1:0]         buf_idx;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic [DATA_WIDTH-1:0] pooled;

  assign in_ready   = (state_q == RUN) && (!out_valid_q || out_ready);
  assign px_fire    = in_valid && in_ready;
  assign out_fire   = out_valid_q && out_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

  assign win_first = (row_q[LOG2K-1:0] == '0) && (col_q[LOG2K-1:0] == '0);
  assign win_last  = (&row_q[LOG2K-1:0]) && (&col_q[LOG2K-1:0]);
  assign last_px   = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
  assign buf_idx   = IW'(col_q >> LOG2K);

  pool_combine #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_combine (
    .init   (win_first),
    .mode   (mode_q),
    .acc    (acc_buf[buf_idx]),
    .pixel  (in_data),
    .result (acc_next)
  );

  // Arithmetic shift floors toward negative infinity, matching the average rounding.
  assign pooled = (mode_q == POOL_AVG) ? DATA_WIDTH'($signed(acc_next) >>> SHIFT)
                                       : DATA_WIDTH'(acc_next);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (px_fire && last_px) state_d = DRAIN;
      DRAIN:   if (out_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= POOL_MAX;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= (state_q == DRAIN) && out_fire;
      if (state_q == IDLE && start) mode_q <= pool_mode_t'(mode);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else if (state_q == IDLE && start) begin
      row_q <= '0;
      col_q <= '0;
    end else if (px_fire) begin
      if (col_q == CW'(IMG_W-1)) begin
        col_q <= '0;
        row_q <= (row_q == RW'(IMG_H-1)) ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // Entries are rebuilt on each window's first pixel, so no reset is needed.
  always_ff @(posedge clk) begin
    if (px_fire) acc_buf[buf_idx] <= acc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (px_fire && win_last) begin
      out_valid_q <= 1'b1;
      out_data_q  <= pooled;
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_stream.sv
// Scoreboard bench for pool_stream: 4x4/K=2 and 8x8/K=4 instances against a window-level model.
module tb_pool_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start_r = 1'b0, mode_r = 1'b0, in_valid_r = 1'b0, out_ready_r = 1'b1, sel = 1'b0;
  logic [15:0] in_data_r = '0;

  logic        a_in_ready, a_out_valid, a_busy, a_frame_done;
  logic [15:0] a_out_data;
  logic        b_in_ready, b_out_valid, b_busy, b_frame_done;
  logic [15:0] b_out_data;

  pool_stream #(.DATA_WIDTH(16), .IMG_W(4), .IMG_H(4), .POOL_K(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_r && !sel), .mode(mode_r),
    .in_valid(in_valid_r && !sel), .in_ready(a_in_ready), .in_data(in_data_r),
    .out_valid(a_out_valid), .out_ready(out_ready_r), .out_data(a_out_data),
    .busy(a_busy), .frame_done(a_frame_done));

  pool_stream #(.DATA_WIDTH(16), .IMG_W(8), .IMG_H(8), .POOL_K(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_r && sel), .mode(mode_r),
    .in_valid(in_valid_r && sel), .in_ready(b_in_ready), .in_data(in_data_r),
    .out_valid(b_out_valid), .out_ready(out_ready_r), .out_data(b_out_data),
    .busy(b_busy), .frame_done(b_frame_done));

  logic        cur_ov, cur_ir, cur_fd, cur_busy;
  logic [15:0] cur_od;
  assign cur_ov   = sel ? b_out_valid  : a_out_valid;
  assign cur_ir   = sel ? b_in_ready   : a_in_ready;
  assign cur_fd   = sel ? b_frame_done : a_frame_done;
  assign cur_busy = sel ? b_busy       : a_busy;
  assign cur_od   = sel ? b_out_data   : a_out_data;

  int          checks = 0, errors = 0;
  logic [15:0] exp_q[$];
  int          done_cnt = 0, exp_done = 0;
  int          pix_q[$];
  int          stall_trig = 0;
  bit          rnd_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // Window-level reference: max or floor(sum / K^2) for each K x K block, raster order.
  function automatic void model(input int w, input int h, input int k, input bit avg,
                                input int px[$], output int res[$]);
    res = {};
    for (int wr = 0; wr < h / k; wr++) begin
      for (int wc = 0; wc < w / k; wc++) begin
        int mx, sum, n, q, v;
        mx  = px[(wr * k) * w + wc * k];
        sum = 0;
        for (int r = 0; r < k; r++) begin
          for (int c = 0; c < k; c++) begin
            v = px[(wr * k + r) * w + wc * k + c];
            sum += v;
            if (v > mx) mx = v;
          end
        end
        n = k * k;
        q = sum / n;
        if (sum < 0 && q * n != sum) q--;
        res.push_back(avg ? q : mx);
      end
    end
  endfunction

  // Downstream ready: free-running, random when enabled, forced low for 10 cycles on request.
  initial begin
    int last = 0;
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_trig != last) begin
        last = stall_trig;
        cnt = 10;
      end
      if (cnt > 0) begin
        out_ready_r = 1'b0;
        cnt--;
      end else begin
        out_ready_r = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // Monitor: pops expected results on every transfer; checks hold-stability and backpressure.
  logic        hold_v = 1'b0;
  logic [15:0] held_d = '0;
  always @(negedge clk) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", cur_ov, 1);
        chk("hold_data", cur_od, held_d);
      end
      if (cur_ov && !out_ready_r) chk("stall_in_ready", cur_ir, 0);
      if (cur_ov && out_ready_r) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0h expected none", cur_od);
        end else begin
          chk("result", cur_od, exp_q.pop_front());
        end
      end
      hold_v = cur_ov && !out_ready_r;
      held_d = cur_od;
      if (cur_fd) done_cnt++;
    end
  end

  task automatic run_frame(input bit s, input bit m, input int abort_after,
                           input bit disturb, input int stall_at);
    int w, h, k, n, t;
    int res[$];
    bit acc;
    w = s ? 8 : 4;
    h = w;
    k = s ? 4 : 2;
    n = w * h;
    if (abort_after < 0) begin
      model(w, h, k, m, pix_q, res);
      foreach (res[j]) exp_q.push_back(16'(res[j]));
      exp_done++;
    end
    sel = s;
    @(posedge clk); #1;
    mode_r = m;
    start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    @(negedge clk);
    chk("busy_run", cur_busy, 1);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      if (i == abort_after) begin
        in_valid_r = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", cur_busy, 0);
        chk("abort_out_valid", cur_ov, 0);
        chk("abort_in_ready", cur_ir, 0);
        chk("abort_out_data", cur_od, 0);
        return;
      end
      if ($urandom_range(0, 4) == 0) begin
        in_valid_r = 1'b0;
        @(posedge clk); #1;
      end
      in_valid_r = 1'b1;
      in_data_r = 16'(pix_q[i]);
      if (disturb && i == n / 2) begin
        start_r = 1'b1;
        mode_r = !m;
      end
      acc = 1'b0;
      t = 0;
      while (!acc) begin
        @(negedge clk);
        acc = cur_ir;
        @(posedge clk); #1;
        start_r = 1'b0;
        t++;
        if (!acc && t > 300) begin
          $display("FAIL pixel_accept_timeout: got no in_ready expected in_ready within 300 cycles");
          errors++;
          $display("CHECKS %0d ERRORS %0d", checks, errors);
          $fatal(1, "pixel accept timeout");
        end
      end
      if (i == stall_at) stall_trig++;
    end
    in_valid_r = 1'b0;
    t = 0;
    while (done_cnt < exp_done && t < 400) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    chk("frame_done_count", done_cnt, exp_done);
    chk("busy_after", cur_busy, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic fill_random(input int n, input bit extremes);
    logic signed [15:0] v;
    pix_q = {};
    for (int i = 0; i < n; i++) begin
      v = $urandom;
      if (extremes) v = ($urandom_range(0, 1) != 0) ? 16'sh7fff : 16'sh8000;
      pix_q.push_back(int'(v));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_a_in_ready", a_in_ready, 0);
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_out_data", a_out_data, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_frame_done", a_frame_done, 0);
    chk("rst_b_in_ready", b_in_ready, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_b_busy", b_busy, 0);

    @(posedge clk); #1;
    in_valid_r = 1'b1;
    in_data_r = 16'h1234;
    @(negedge clk);
    chk("idle_in_ready", a_in_ready, 0);
    @(posedge clk); #1;
    in_valid_r = 1'b0;
    @(negedge clk);
    chk("idle_out_valid", a_out_valid, 0);

    // 4x4 raster 1..16, max
    pix_q = {};
    for (int i = 1; i <= 16; i++) pix_q.push_back(i);
    run_frame(0, 0, -1, 0, -1);

    // all -3 except one window {-1,-2,-3,-4}, average
    pix_q = {};
    for (int i = 0; i < 16; i++) pix_q.push_back(-3);
    pix_q[2] = -1; pix_q[3] = -2; pix_q[6] = -3; pix_q[7] = -4;
    run_frame(0, 1, -1, 0, -1);

    // 8x8 raster 0..63, K=4, max then average
    pix_q = {};
    for (int i = 0; i < 64; i++) pix_q.push_back(i);
    run_frame(1, 0, -1, 0, -1);
    run_frame(1, 1, -1, 0, -1);

    // randomized frames with random downstream backpressure
    rnd_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      fill_random(16, f >= 4);
      run_frame(0, f[0], -1, 0, -1);
    end
    for (int f = 0; f < 4; f++) begin
      fill_random(64, f >= 2);
      run_frame(1, f[0], -1, 0, -1);
    end

    // downstream held off for 10 cycles with a result pending
    rnd_ready = 1'b0;
    fill_random(16, 0);
    run_frame(0, 1, -1, 0, 4);
    fill_random(64, 0);
    run_frame(1, 0, -1, 0, 20);

    // reset after 5 pixels, then a full frame
    fill_random(16, 0);
    run_frame(0, 1, 5, 0, -1);
    fill_random(16, 0);
    run_frame(0, 1, -1, 0, -1);

    // start pulsed and mode toggled mid-frame
    rnd_ready = 1'b1;
    fill_random(16, 0);
    run_frame(0, 0, -1, 1, -1);
    fill_random(16, 0);
    run_frame(0, 1, -1, 1, -1);
    fill_random(64, 0);
    run_frame(1, 1, -1, 1, -1);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_frame_count", done_cnt, exp_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_stream.md
POOL_STREAM -- requirements
Module: pool_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 16: signed pixel width (two's complement).
REQ-002 Parameter IMG_W, default 28: input frame width in pixels.
REQ-003 Parameter IMG_H, default 28: input frame height in pixels.
REQ-004 Parameter POOL_K, default 2: square window size and stride (non-overlapping); legal values 2 and 4.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  reset is synchronous and active-high.
REQ-007 start  in  1  one-cycle pulse; begins a frame; ignored unless IDLE.
REQ-008 mode  in  1  0 = max pool, 1 = average pool; sampled only on accepted start.
REQ-009 in_valid  in  1  in_data holds a valid pixel.
REQ-010 in_ready  out  1  block accepts pixel this cycle.
REQ-011 in_data  in  DATA_WIDTH  pixel, raster order (row-major, col 0 first).
REQ-012 out_valid  out  1  out_data holds a pooled result.
REQ-013 out_ready  in  1  downstream accepts out_data this cycle.
REQ-014 out_data  out  DATA_WIDTH  pooled result, raster order over (IMG_H/K) x (IMG_W/K).
REQ-015 busy  out  1  high in RUN and DRAIN.
REQ-016 frame_done  out  1  one-cycle pulse after last result of frame is accepted.

Function
REQ-017 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN when last pixel (IMG_H-1, IMG_W-1) accepted; DRAIN->IDLE when last result accepted, with frame_done high that cycle's next edge (registered, one cycle).
REQ-018 Pixel transfer occurs iff in_valid && in_ready; result transfer iff out_valid && out_ready.
REQ-019 in_ready = (state==RUN) && (!out_valid || out_ready); combinational, no dependency on in_valid.
REQ-020 Row/column counters advance only on pixel transfer; column wraps at IMG_W-1 to 0 and increments row.
REQ-021 Column accumulator buffer of IMG_W/K entries holds partial results for the current window row band; entry index = col / K.
REQ-022 First pixel of a window (row%K==0 and col%K==0) initialises its entry; later pixels combine: max mode keeps signed maximum, average mode adds.
REQ-023 Accumulator width DATA_WIDTH + 2*log2(K); sign-extend inputs; no overflow possible.
REQ-024 Average result = accumulated sum arithmetic-shifted right by 2*log2(K) (floor toward negative infinity), truncated to DATA_WIDTH.
REQ-025 On transfer of a window's last pixel (row%K==K-1 and col%K==K-1), result is registered into out_data with out_valid high on the next cycle (latency 1).
REQ-026 out_valid and out_data hold stable until transferred; out_valid drops after transfer unless a new result loads the same cycle.
REQ-027 Simultaneous result transfer and new result load: new result wins, out_valid stays high.
REQ-028 mode held in a register for the whole frame; changes on mode input mid-frame have no effect.
REQ-029 start while busy is ignored; frame state untouched.
REQ-030 in_valid outside RUN is ignored (in_ready low).
REQ-031 IMG_W and IMG_H not divisible by POOL_K, or illegal POOL_K: elaboration-time fatal error.

Reset
REQ-032 reset forces state IDLE, counters 0, out_valid 0, out_data 0, frame_done 0, busy 0, in_ready 0, mode register 0 on the next edge.
REQ-033 reset mid-frame abandons the frame; no frame_done; accumulator buffer contents are don't-care (reinitialised per REQ-022).
REQ-034 reset has priority over start, and over all transfers, in the same cycle.

Structure
REQ-035 Shared package holds pool_mode_t (POOL_MAX, POOL_AVG), pool_stream_state_t (IDLE, RUN, DRAIN) and default DATA_WIDTH/IMG/POOL_K constants.
REQ-036 One sub-module pool_combine: combinational init/max/add of accumulator entry with sign-extended pixel, parametrised on widths.

Verification
REQ-037 IMG 4x4, K=2, max, rows 1..16 (1 2 3 4 / 5 6 7 8 / ...), out_ready=1 -> outputs 6, 8, 14, 16 then frame_done pulse.
REQ-038 Same frame, avg mode, pixels all -3 except one window {-1,-2,-3,-4} -> that result -3 (floor of -2.5), others -3.
REQ-039 K=4, IMG 8x8, values 0..63 raster, max -> 27, 31, 59, 63; avg -> 13, 17, 45, 49.
REQ-040 out_ready low 10 cycles while results pending -> in_ready low, out_data stable, no results lost or duplicated; totals match golden.
REQ-041 reset asserted after 5 pixels, then new start with full frame -> correct outputs, no stale values, exactly one frame_done.
REQ-042 start pulsed and mode toggled mid-frame -> ignored; outputs match original mode.
